// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory toggle-handshake buses around the port arbiter.
// The master view belongs to the arbiter; the slave view belongs to the surrounding requesters and memory.
interface mem_port_arbiter_if;
    logic        fTriggerIn;
    logic [31:0] fAddrIn;
    logic [31:0] fDataOut;
    logic        fReadyOut;
    logic        dTriggerIn;
    logic [31:0] dAddrIn;
    logic        dWriteIn;
    logic [31:0] dWdataIn;
    logic [31:0] dDataOut;
    logic        dReadyOut;
    logic        memTriggerOut;
    logic [31:0] memAddrOut;
    logic        memWriteOut;
    logic [31:0] memWdataOut;
    logic [31:0] memDataIn;
    logic        memReadyIn;
    logic [1:0]  grantOut;
    logic        errorOut;
    logic        errClrIn;

    modport master (
        input  fTriggerIn, fAddrIn, dTriggerIn, dAddrIn, dWriteIn, dWdataIn,
               memDataIn, memReadyIn, errClrIn,
        output fDataOut, fReadyOut, dDataOut, dReadyOut, memTriggerOut,
               memAddrOut, memWriteOut, memWdataOut, grantOut, errorOut
    );

    modport slave (
        output fTriggerIn, fAddrIn, dTriggerIn, dAddrIn, dWriteIn, dWdataIn,
               memDataIn, memReadyIn, errClrIn,
        input  fDataOut, fReadyOut, dDataOut, dReadyOut, memTriggerOut,
               memAddrOut, memWriteOut, memWdataOut, grantOut, errorOut
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake memory port between fetch (F) and load/store (D),
// with one transaction in flight at a time and a watchdog that force-completes hung transactions.
module mem_port_arbiter #(
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The watchdog fires on the last permitted WAIT cycle, so WAIT lasts exactly TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] fSyncR;
    logic [SYNC_STAGES-1:0] dSyncR;
    logic [SYNC_STAGES-1:0] mSyncR;
    logic                   fSyncS;
    logic                   dSyncS;
    logic                   mSyncS;

    state_t      stateR;
    state_t      stateNextS;
    logic        fPendS;
    logic        dPendS;
    logic        grantFS;
    logic        grantDS;
    logic        doneS;
    logic        timeoutS;

    logic [7:0]  cntR;
    logic [31:0] rdataR;
    logic        lastGrantDR;
    logic        memTrigR;
    logic [31:0] memAddrR;
    logic        memWriteR;
    logic [31:0] memWdataR;
    logic [1:0]  grantR;
    logic [31:0] fDataR;
    logic        fReadyR;
    logic [31:0] dDataR;
    logic        dReadyR;
    logic        errorR;

    assign fSyncS = fSyncR[SYNC_STAGES-1];
    assign dSyncS = dSyncR[SYNC_STAGES-1];
    assign mSyncS = mSyncR[SYNC_STAGES-1];

    assign fPendS = fSyncS != fReadyR;
    assign dPendS = dSyncS != dReadyR;

    // Synchronizer chains for the three incoming toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fSyncR <= '0;
            dSyncR <= '0;
            mSyncR <= '0;
        end else begin
            fSyncR <= SYNC_STAGES'({fSyncR, bus.fTriggerIn});
            dSyncR <= SYNC_STAGES'({dSyncR, bus.dTriggerIn});
            mSyncR <= SYNC_STAGES'({mSyncR, bus.memReadyIn});
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Next-state logic: grant selection in IDLE, completion or watchdog expiry in WAIT.
    always_comb begin
        stateNextS = stateR;
        grantFS    = 1'b0;
        grantDS    = 1'b0;
        doneS      = 1'b0;
        timeoutS   = 1'b0;
        case (stateR)
            IDLE: begin
                // F wins a tie only when D held the previous grant.
                if (fPendS && (!dPendS || lastGrantDR)) begin
                    grantFS    = 1'b1;
                    stateNextS = WAIT;
                end else if (dPendS) begin
                    grantDS    = 1'b1;
                    stateNextS = WAIT;
                end else begin
                    stateNextS = IDLE;
                end
            end
            WAIT: begin
                if (mSyncS == memTrigR) begin
                    doneS      = 1'b1;
                    stateNextS = RESP;
                end else if (cntR == TIMEOUT_LAST) begin
                    timeoutS   = 1'b1;
                    stateNextS = RESP;
                end else begin
                    stateNextS = WAIT;
                end
            end
            RESP: begin
                stateNextS = IDLE;
            end
            default: begin
                stateNextS = IDLE;
            end
        endcase
    end

    // Transaction datapath: request latch on grant, response capture, requester completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memTrigR    <= 1'b0;
            memAddrR    <= 32'd0;
            memWriteR   <= 1'b0;
            memWdataR   <= 32'd0;
            grantR      <= 2'b00;
            cntR        <= 8'd0;
            rdataR      <= 32'd0;
            fDataR      <= 32'd0;
            fReadyR     <= 1'b0;
            dDataR      <= 32'd0;
            dReadyR     <= 1'b0;
            lastGrantDR <= 1'b1;
        end else begin
            case (stateR)
                IDLE: begin
                    if (grantFS) begin
                        memAddrR  <= bus.fAddrIn;
                        memWriteR <= 1'b0;
                        memWdataR <= 32'd0;
                        grantR    <= 2'b01;
                        memTrigR  <= ~memTrigR;
                        cntR      <= 8'd0;
                    end else if (grantDS) begin
                        memAddrR  <= bus.dAddrIn;
                        memWriteR <= bus.dWriteIn;
                        memWdataR <= bus.dWdataIn;
                        grantR    <= 2'b10;
                        memTrigR  <= ~memTrigR;
                        cntR      <= 8'd0;
                    end
                end
                WAIT: begin
                    if (doneS) begin
                        rdataR <= bus.memDataIn;
                    end else if (timeoutS) begin
                        rdataR <= ERR_DATA;
                    end else begin
                        cntR <= cntR + 8'd1;
                    end
                end
                RESP: begin
                    if (grantR[0]) begin
                        fDataR  <= rdataR;
                        fReadyR <= ~fReadyR;
                    end else begin
                        // Writes leave the D read-data register untouched.
                        if (!memWriteR) begin
                            dDataR <= rdataR;
                        end
                        dReadyR <= ~dReadyR;
                    end
                    lastGrantDR <= grantR[1];
                    grantR      <= 2'b00;
                end
                default: begin
                    grantR <= 2'b00;
                end
            endcase
        end
    end

    // Sticky watchdog flag; a timeout in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errorR <= 1'b0;
        end else if (timeoutS) begin
            errorR <= 1'b1;
        end else if (bus.errClrIn) begin
            errorR <= 1'b0;
        end
    end

    assign bus.memTriggerOut = memTrigR;
    assign bus.memAddrOut    = memAddrR;
    assign bus.memWriteOut   = memWriteR;
    assign bus.memWdataOut   = memWdataR;
    assign bus.grantOut      = grantR;
    assign bus.fDataOut      = fDataR;
    assign bus.fReadyOut     = fReadyR;
    assign bus.dDataOut      = dDataR;
    assign bus.dReadyOut     = dReadyR;
    assign bus.errorOut      = errorR;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory requests and port
// responses; a negedge monitor pops and compares whenever a handshake toggle appears.
module tb_mem_port_arbiter;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  grant;
    } memExp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    memExp_t     memQ[$];
    logic [31:0] fQ[$];
    logic [31:0] dQ[$];
    logic [31:0] memDataQ[$];

    int   lastMemTrigCyc = 0;
    int   lastFReadyCyc  = 0;
    int   lastDReadyCyc  = 0;
    int   lastMemRespCyc = 0;
    int   trigCyc        = 0;
    logic saw11          = 1'b0;

    logic memAuto  = 1'b1;
    int   memDelay = 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic failNote(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s actual=%s", nm, what);
    endtask

    // Monitor: every toggle on a DUT handshake output consumes one scoreboard entry.
    logic pMemTrig = 1'b0;
    logic pFReady  = 1'b0;
    logic pDReady  = 1'b0;
    always @(negedge clk) begin
        memExp_t e;
        if (rst) begin
            pMemTrig = 1'b0;
            pFReady  = 1'b0;
            pDReady  = 1'b0;
        end else begin
            if (bus.grantOut == 2'b11) saw11 = 1'b1;
            if (bus.memTriggerOut !== pMemTrig) begin
                lastMemTrigCyc = cyc;
                if (memQ.size() == 0) begin
                    failNote("mem-req", "unexpected memTriggerOut toggle");
                end else begin
                    e = memQ.pop_front();
                    check("mem-addr",  bus.memAddrOut,         e.addr);
                    check("mem-write", 32'(bus.memWriteOut),   32'(e.wr));
                    check("mem-wdata", bus.memWdataOut,        e.wdata);
                    check("mem-grant", 32'(bus.grantOut),      32'(e.grant));
                end
            end
            if (bus.fReadyOut !== pFReady) begin
                lastFReadyCyc = cyc;
                if (fQ.size() == 0) failNote("f-resp", "unexpected fReadyOut toggle");
                else check("f-data", bus.fDataOut, fQ.pop_front());
            end
            if (bus.dReadyOut !== pDReady) begin
                lastDReadyCyc = cyc;
                if (dQ.size() == 0) failNote("d-resp", "unexpected dReadyOut toggle");
                else check("d-data", bus.dDataOut, dQ.pop_front());
            end
            pMemTrig = bus.memTriggerOut;
            pFReady  = bus.fReadyOut;
            pDReady  = bus.dReadyOut;
        end
    end

    // Memory model: answers each request memDelay cycles later with the next queued word.
    logic mPrev   = 1'b0;
    logic memBusy = 1'b0;
    int   memCnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            bus.memReadyIn = 1'b0;
            bus.memDataIn  = 32'd0;
            memBusy        = 1'b0;
            mPrev          = 1'b0;
        end else begin
            if (memBusy) begin
                if (memCnt <= 1) begin
                    if (memDataQ.size() > 0) bus.memDataIn = memDataQ.pop_front();
                    else bus.memDataIn = 32'd0;
                    bus.memReadyIn = ~bus.memReadyIn;
                    lastMemRespCyc = cyc;
                    memBusy        = 1'b0;
                end else begin
                    memCnt--;
                end
            end
            if (bus.memTriggerOut !== mPrev && memAuto) begin
                memBusy = 1'b1;
                memCnt  = memDelay;
            end
            mPrev = bus.memTriggerOut;
        end
    end

    task automatic reqF(input logic [31:0] addr);
        @(negedge clk);
        bus.fAddrIn    = addr;
        bus.fTriggerIn = ~bus.fTriggerIn;
        trigCyc        = cyc;
    endtask

    task automatic reqD(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        @(negedge clk);
        bus.dAddrIn    = addr;
        bus.dWriteIn   = wr;
        bus.dWdataIn   = wdata;
        bus.dTriggerIn = ~bus.dTriggerIn;
        trigCyc        = cyc;
    endtask

    task automatic waitIdle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.grantOut == 2'b00 && bus.fReadyOut == bus.fTriggerIn &&
                     bus.dReadyOut == bus.dTriggerIn) && n < 200);
        if (n >= 200) failNote(nm, "no completion within 200 cycles");
        @(negedge clk);
    endtask

    task automatic waitMemTrig(input logic lvl, input string nm, output int c);
        int n = 0;
        while (bus.memTriggerOut == lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) failNote(nm, "no memTriggerOut toggle within 40 cycles");
        c = cyc;
    endtask

    task automatic checkAllZero(input string p);
        check({p, "-fData"},   bus.fDataOut,                32'd0);
        check({p, "-fReady"},  32'(bus.fReadyOut),          32'd0);
        check({p, "-dData"},   bus.dDataOut,                32'd0);
        check({p, "-dReady"},  32'(bus.dReadyOut),          32'd0);
        check({p, "-memTrig"}, 32'(bus.memTriggerOut),      32'd0);
        check({p, "-memAddr"}, bus.memAddrOut,              32'd0);
        check({p, "-memWr"},   32'(bus.memWriteOut),        32'd0);
        check({p, "-memWd"},   bus.memWdataOut,             32'd0);
        check({p, "-grant"},   32'(bus.grantOut),           32'd0);
        check({p, "-error"},   32'(bus.errorOut),           32'd0);
    endtask

    // Requesters and memory are reset together with the arbiter.
    task automatic doReset(input logic checkAsync);
        @(negedge clk);
        #2;
        rst            = 1'b1;
        bus.fTriggerIn = 1'b0;
        bus.dTriggerIn = 1'b0;
        bus.errClrIn   = 1'b0;
        #1;
        if (checkAsync) checkAllZero("rst-async");
        repeat (3) @(negedge clk);
        memQ.delete();
        fQ.delete();
        dQ.delete();
        memDataQ.delete();
        rst = 1'b0;
    endtask

    initial begin
        int   g;
        logic lvl;
        bus.fTriggerIn = 1'b0;
        bus.fAddrIn    = 32'd0;
        bus.dTriggerIn = 1'b0;
        bus.dAddrIn    = 32'd0;
        bus.dWriteIn   = 1'b0;
        bus.dWdataIn   = 32'd0;
        bus.errClrIn   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Tie straight out of reset: F first, then D.
        memDelay = 2;
        memQ.push_back('{32'h0000_0500, 1'b0, 32'd0, 2'b01});
        memQ.push_back('{32'h0000_0600, 1'b0, 32'd0, 2'b10});
        memDataQ.push_back(32'h1111_1111);
        memDataQ.push_back(32'h2222_2222);
        fQ.push_back(32'h1111_1111);
        dQ.push_back(32'h2222_2222);
        @(negedge clk);
        bus.fAddrIn    = 32'h0000_0500;
        bus.dAddrIn    = 32'h0000_0600;
        bus.dWriteIn   = 1'b0;
        bus.fTriggerIn = ~bus.fTriggerIn;
        bus.dTriggerIn = ~bus.dTriggerIn;
        waitIdle("tie1-idle");

        // A lone F grant makes F the last owner, so the next tie goes to D.
        memQ.push_back('{32'h0000_0700, 1'b0, 32'd0, 2'b01});
        memDataQ.push_back(32'h3333_3333);
        fQ.push_back(32'h3333_3333);
        reqF(32'h0000_0700);
        waitIdle("f700-idle");

        memQ.push_back('{32'h0000_0800, 1'b0, 32'd0, 2'b10});
        memQ.push_back('{32'h0000_0900, 1'b0, 32'd0, 2'b01});
        memDataQ.push_back(32'h4444_4444);
        memDataQ.push_back(32'h5555_5555);
        dQ.push_back(32'h4444_4444);
        fQ.push_back(32'h5555_5555);
        @(negedge clk);
        bus.fAddrIn    = 32'h0000_0900;
        bus.dAddrIn    = 32'h0000_0800;
        bus.fTriggerIn = ~bus.fTriggerIn;
        bus.dTriggerIn = ~bus.dTriggerIn;
        waitIdle("tie2-idle");

        // F alone with a 3-cycle memory.
        memDelay = 3;
        memQ.push_back('{32'h0000_0100, 1'b0, 32'd0, 2'b01});
        memDataQ.push_back(32'h0000_00FF);
        fQ.push_back(32'h0000_00FF);
        reqF(32'h0000_0100);
        waitIdle("f100-idle");
        // Trigger sampled at the next edge, visible after SYNC edges, granted one edge later.
        check("f-trig-latency", 32'(lastMemTrigCyc - trigCyc), 32'(SYNC + 1));
        // The memory toggle is first sampled one edge after it is driven.
        check("f-ready-latency", 32'(lastFReadyCyc - (lastMemRespCyc + 1)), 32'(SYNC + 1));
        check("f-grant-idle", 32'(bus.grantOut), 32'd0);
        check("f-addr-held", bus.memAddrOut, 32'h0000_0100);

        // D read, then D write that must leave dDataOut at the read value.
        memQ.push_back('{32'h0000_3000, 1'b0, 32'd0, 2'b10});
        memDataQ.push_back(32'h55AA_55AA);
        dQ.push_back(32'h55AA_55AA);
        reqD(32'h0000_3000, 1'b0, 32'd0);
        waitIdle("drd-idle");
        memQ.push_back('{32'h0000_2000, 1'b1, 32'h1234_5678, 2'b10});
        memDataQ.push_back(32'h0BAD_0BAD);
        dQ.push_back(32'h55AA_55AA);
        reqD(32'h0000_2000, 1'b1, 32'h1234_5678);
        waitIdle("dwr-idle");
        check("dwr-wdata-held", bus.memWdataOut, 32'h1234_5678);

        // Back-to-back: D requested while F waits, granted in the IDLE right after F's RESP.
        memDelay = 5;
        memQ.push_back('{32'h0000_0A00, 1'b0, 32'd0, 2'b01});
        memQ.push_back('{32'h0000_0B00, 1'b0, 32'd0, 2'b10});
        memDataQ.push_back(32'h6666_6666);
        memDataQ.push_back(32'h7777_7777);
        fQ.push_back(32'h6666_6666);
        dQ.push_back(32'h7777_7777);
        lvl = bus.memTriggerOut;
        reqF(32'h0000_0A00);
        waitMemTrig(lvl, "b2b-grant", g);
        reqD(32'h0000_0B00, 1'b0, 32'd0);
        waitIdle("b2b-idle");
        check("b2b-gap", 32'(lastMemTrigCyc - lastFReadyCyc), 32'd1);

        // Watchdog: silent memory, WAIT lasts TMO cycles, then RESP.
        memAuto = 1'b0;
        memQ.push_back('{32'h0000_0400, 1'b0, 32'd0, 2'b01});
        fQ.push_back(32'hDEAD_BEEF);
        lvl = bus.memTriggerOut;
        reqF(32'h0000_0400);
        waitMemTrig(lvl, "tmo1-grant", g);
        waitIdle("tmo1-idle");
        check("tmo1-latency", 32'(lastFReadyCyc - g), 32'(TMO + 1));
        check("tmo1-error", 32'(bus.errorOut), 32'd1);
        @(negedge clk);
        bus.errClrIn = 1'b1;
        @(negedge clk);
        bus.errClrIn = 1'b0;
        check("err-clear", 32'(bus.errorOut), 32'd0);

        // Second timeout coincident with errClrIn: set wins.
        doReset(1'b0);
        memQ.push_back('{32'h0000_0404, 1'b0, 32'd0, 2'b01});
        fQ.push_back(32'hDEAD_BEEF);
        lvl = bus.memTriggerOut;
        reqF(32'h0000_0404);
        waitMemTrig(lvl, "tmo2-grant", g);
        repeat (TMO - 1) @(negedge clk);
        bus.errClrIn = 1'b1;
        @(negedge clk);
        bus.errClrIn = 1'b0;
        check("err-set-wins", 32'(bus.errorOut), 32'd1);
        waitIdle("tmo2-idle");
        check("err-sticky", 32'(bus.errorOut), 32'd1);

        // Reset in the middle of a D write's WAIT, then a fresh F read.
        doReset(1'b0);
        memQ.push_back('{32'h0000_0C00, 1'b1, 32'h0000_9999, 2'b10});
        dQ.push_back(32'd0);
        lvl = bus.memTriggerOut;
        reqD(32'h0000_0C00, 1'b1, 32'h0000_9999);
        waitMemTrig(lvl, "rst-grant", g);
        repeat (2) @(negedge clk);
        doReset(1'b1);
        memAuto  = 1'b1;
        memDelay = 2;
        memQ.push_back('{32'h0000_0100, 1'b0, 32'd0, 2'b01});
        memDataQ.push_back(32'hCAFE_F00D);
        fQ.push_back(32'hCAFE_F00D);
        reqF(32'h0000_0100);
        waitIdle("post-rst-idle");

        check("queues-drained", 32'(memQ.size() + fQ.size() + dQ.size()), 32'd0);
        check("grant-never-11", 32'(saw11), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
